// File: rtl/io_panel_ctrl.sv
// Board-side I/O panel: debounces two 6-bit switch groups for the CPU input
// ports and scans the low byte of four CPU output ports onto an 8-digit display.
module io_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_CYCLES     = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [5:0]  sw0,
  input  logic [5:0]  sw1,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  input  logic [31:0] out_port3,
  output logic [5:0]  in_port0,
  output logic [5:0]  in_port1,
  output logic        in_change,
  output logic [7:0]  seg_an,
  output logic [6:0]  seg_n
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_CYCLES - 1);

  function automatic logic [6:0] hex_enc(input logic [3:0] nib);
    case (nib)
      4'h0: hex_enc = 7'h3F;
      4'h1: hex_enc = 7'h06;
      4'h2: hex_enc = 7'h5B;
      4'h3: hex_enc = 7'h4F;
      4'h4: hex_enc = 7'h66;
      4'h5: hex_enc = 7'h6D;
      4'h6: hex_enc = 7'h7D;
      4'h7: hex_enc = 7'h07;
      4'h8: hex_enc = 7'h7F;
      4'h9: hex_enc = 7'h6F;
      4'hA: hex_enc = 7'h77;
      4'hB: hex_enc = 7'h7C;
      4'hC: hex_enc = 7'h39;
      4'hD: hex_enc = 7'h5E;
      4'hE: hex_enc = 7'h79;
      default: hex_enc = 7'h71;
    endcase
  endfunction

  logic [1:0][5:0]       sw_raw;
  logic [1:0][5:0]       sync_p0;
  logic [1:0][5:0]       sync_p1;
  logic [1:0][5:0]       cand;
  logic [1:0][5:0]       stable;
  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0]            chg_req;

  logic [SCAN_W-1:0]     scan_cnt;
  logic [2:0]            digit;
  logic                  scan_wrap;
  logic                  frame_end;
  logic [3:0][7:0]       snap;
  logic [3:0]            nibble;
  logic                  unused_hi;

  assign sw_raw    = {sw1, sw0};
  assign unused_hi = ^{out_port0[31:8], out_port1[31:8], out_port2[31:8], out_port3[31:8]};

  // Stage p0/p1: two-flop synchronizer for the asynchronous switch pins
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sw_raw;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    chg_req = '0;
    for (int g = 0; g < 2; g++) begin
      chg_req[g] = (sync_p1[g] == cand[g]) && (cnt[g] == CNT_MAX) && (stable[g] != cand[g]);
    end
  end

  // Debounce stage: a group is accepted only after CNT_MAX+1 unchanged samples
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cand      <= '0;
      cnt       <= '0;
      stable    <= '0;
      in_change <= 1'b0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (sync_p1[g] != cand[g]) begin
          cand[g] <= sync_p1[g];
          cnt[g]  <= '0;
        end else if (cnt[g] != CNT_MAX) begin
          cnt[g]  <= cnt[g] + CNT_W'(1);
        end else if (stable[g] != cand[g]) begin
          stable[g] <= cand[g];
        end
      end
      in_change <= |chg_req;
    end
  end

  assign in_port0 = stable[0];
  assign in_port1 = stable[1];

  assign scan_wrap = (scan_cnt == SCAN_MAX);
  assign frame_end = scan_wrap && (digit == 3'd7);

  // Scan stage: digit advance and per-frame snapshot of the displayed bytes
  always_ff @(posedge clock) begin
    if (!resetn) begin
      scan_cnt <= '0;
      digit    <= '0;
      snap     <= '0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
      if (scan_wrap) digit <= digit + 3'd1;
      if (frame_end) snap <= {out_port3[7:0], out_port2[7:0], out_port1[7:0], out_port0[7:0]};
    end
  end

  always_comb begin
    nibble = digit[0] ? snap[digit[2:1]][7:4] : snap[digit[2:1]][3:0];
  end

  // Output stage: registered digit enable and segment pattern
  always_ff @(posedge clock) begin
    if (!resetn) begin
      seg_an <= 8'hFF;
      seg_n  <= 7'h7F;
    end else begin
      seg_an <= ~(8'd1 << digit);
      seg_n  <= ~hex_enc(nibble);
    end
  end

endmodule

// File: tb/tb_io_panel_ctrl.sv
// Directed bench for io_panel_ctrl: switch-change events go through a queue of
// expected pulses; display cadence and decode are checked against fixed values.
module tb_io_panel_ctrl;

  localparam int DEB  = 16;
  localparam int SCAN = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic [5:0]  sw0, sw1;
  logic [31:0] out_port0, out_port1, out_port2, out_port3;
  logic [5:0]  in_port0, in_port1;
  logic        in_change;
  logic [7:0]  seg_an;
  logic [6:0]  seg_n;

  typedef struct {
    int         at_edge;
    logic [5:0] p0;
    logic [5:0] p1;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         ph = 0;
  bit         mon_en = 1'b0;
  logic [5:0] cur0 = '0;
  logic [5:0] cur1 = '0;

  io_panel_ctrl #(.DEBOUNCE_CYCLES(DEB), .SCAN_CYCLES(SCAN)) dut (
    .clock(clock), .resetn(resetn), .sw0(sw0), .sw1(sw1),
    .out_port0(out_port0), .out_port1(out_port1),
    .out_port2(out_port2), .out_port3(out_port3),
    .in_port0(in_port0), .in_port1(in_port1), .in_change(in_change),
    .seg_an(seg_an), .seg_n(seg_n)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    ph  <= resetn ? ph + 1 : 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Continuous monitor: reset values, digit cadence, in_change pulses vs queue.
  always @(negedge clock) begin
    logic [7:0] exp_an;
    exp_t       e;
    if (mon_en) begin
      if (ph == 0) begin
        cur0 = '0;
        cur1 = '0;
        check("rst_seg_an", seg_an, 8'hFF);
        check("rst_seg_n", seg_n, 7'h7F);
        check("rst_in_change", in_change, 1'b0);
      end else begin
        exp_an = ~(8'd1 << (((ph - 1) / SCAN) % 8));
        check("scan_seg_an", seg_an, exp_an);
        if (in_change) begin
          if (q.size() == 0) begin
            check("spurious_in_change", in_change, 1'b0);
          end else begin
            e = q.pop_front();
            check("chg_edge", cyc, e.at_edge);
            cur0 = e.p0;
            cur1 = e.p1;
          end
        end
      end
      check("in_port0", in_port0, cur0);
      check("in_port1", in_port1, cur1);
    end
  end

  task automatic wait_ph(input int t);
    int k = 0;
    while (ph != t && k < 300) begin
      @(negedge clock);
      k++;
    end
    if (ph != t) check("wait_ph_timeout", ph, t);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 80 && q.size() != 0; k++) @(negedge clock);
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic expect_seg(input string tag, input int t, input logic [7:0] an, input logic [6:0] sn);
    wait_ph(t);
    check({tag, "_an"}, seg_an, an);
    check({tag, "_n"}, seg_n, sn);
  endtask

  initial begin
    resetn = 1'b0;
    sw0 = '0;
    sw1 = '0;
    out_port0 = 32'hA5;
    out_port1 = '0;
    out_port2 = '0;
    out_port3 = '0;
    repeat (2) @(negedge clock);
    mon_en = 1'b1;

    // Reset in the middle of a scan
    resetn = 1'b1;
    expect_seg("first_digit", 1, 8'hFE, 7'h40);
    repeat (19) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check("midrst_seg_an", seg_an, 8'hFF);
    check("midrst_seg_n", seg_n, 7'h7F);
    check("midrst_in_port0", in_port0, 6'h00);
    check("midrst_in_port1", in_port1, 6'h00);
    check("midrst_in_change", in_change, 1'b0);
    resetn = 1'b1;
    @(negedge clock);
    check("after_rst_seg_an", seg_an, 8'hFE);

    // Display decode and frame coherence
    resetn = 1'b0;
    out_port0 = 32'hFFFF_FF3C;
    out_port1 = 32'h0000_0011;
    out_port2 = 32'h0000_0000;
    out_port3 = 32'h0000_00E9;
    @(negedge clock);
    resetn = 1'b1;
    expect_seg("frame0_zero", 1, 8'hFE, 7'h40);
    expect_seg("dec_C", 33, 8'hFE, 7'h46);
    expect_seg("dec_3", 37, 8'hFD, 7'h30);
    expect_seg("dec_1", 41, 8'hFB, 7'h79);
    expect_seg("dec_0", 49, 8'hEF, 7'h40);
    expect_seg("dec_9", 57, 8'hBF, 7'h10);
    expect_seg("dec_E", 61, 8'h7F, 7'h06);
    wait_ph(73);
    out_port1 = 32'h0000_0022;
    expect_seg("coh_d2_old", 74, 8'hFB, 7'h79);
    expect_seg("coh_d3_old", 78, 8'hF7, 7'h79);
    expect_seg("coh_d2_new", 105, 8'hFB, 7'h24);
    expect_seg("coh_d3_new", 109, 8'hF7, 7'h24);

    // Clean switch change: pulse 19 edges after the drive point
    @(negedge clock);
    sw0 = 6'h2D;
    q.push_back('{cyc + DEB + 3, 6'h2D, 6'h00});
    wait_drain();
    repeat (4) @(negedge clock);

    // Bounce rejection on sw1
    for (int i = 0; i < 12; i++) begin
      sw1 = (i % 2 == 0) ? 6'h3F : 6'h00;
      repeat (5) @(negedge clock);
      check("bounce_hold", in_port1, 6'h00);
    end
    sw1 = 6'h3F;
    q.push_back('{cyc + DEB + 3, 6'h2D, 6'h3F});
    wait_drain();
    repeat (4) @(negedge clock);

    // Both groups change on the same cycle
    sw0 = 6'h01;
    sw1 = 6'h02;
    q.push_back('{cyc + DEB + 3, 6'h01, 6'h02});
    wait_drain();
    repeat (5) @(negedge clock);
    check("simul_in_port0", in_port0, 6'h01);
    check("simul_in_port1", in_port1, 6'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_panel_ctrl.md
# io_panel_ctrl

Board-side counterpart of the pipelined computer's memory-mapped I/O ports. It turns raw switch inputs into debounced, synchronized values for the CPU's two 6-bit input ports. It also renders the low byte of each of the CPU's four 32-bit output ports as two hex digits on an 8-digit multiplexed seven-segment display. It sits at the board top level, between the pins and the pipelined computer's in_port0/in_port1 and out_port0..out_port3.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a switch group is accepted (≥2).
- SCAN_CYCLES, 4: clock cycles each display digit stays enabled (≥1).

- clock  in  1  single system clock; all registers update on the rising edge.
- resetn  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- sw0  in  6  raw, asynchronous switch group 0.
- sw1  in  6  raw, asynchronous switch group 1.
- out_port0..out_port3  in  32 each  CPU output ports; only bits [7:0] are displayed.
- in_port0  out  6  debounced sw0, to the CPU.
- in_port1  out  6  debounced sw1, to the CPU.
- in_change  out  1  one-cycle pulse when in_port0 and/or in_port1 changes.
- seg_an  out  8  digit enables, active-low, one-hot-cold; bit k selects digit k.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- **Synchronizer.** Each switch group passes through a 2-flop synchronizer: raw → s1 → s2.

- **Debouncer.** Each group has its own candidate register `cand`, counter `cnt` (width ⌈log2 DEBOUNCE_CYCLES⌉) and stable output. On each edge, the first matching rule applies:
  - If s2 ≠ cand: cand ← s2 and cnt ← 0.
  - Else if cnt ≠ DEBOUNCE_CYCLES−1: cnt ← cnt+1.
  - Else if stable ≠ cand: stable ← cand, and that group requests a change.
  - in_change is registered and equals the OR of both groups' change requests. Simultaneous updates in both groups give a single one-cycle pulse.
  - A bounce shorter than DEBOUNCE_CYCLES cycles restarts the count and never reaches in_port.

- **Scanner.**
  - scan_cnt counts 0..SCAN_CYCLES−1 and wraps.
  - digit (3 bits) increments when scan_cnt wraps; 7 wraps to 0.

- **Snapshot.**
  - Register snap (4×8 bits) loads out_portp[7:0] for all p on the edge where digit wraps 7→0, i.e. at digit==7 and scan_cnt==SCAN_CYCLES−1.
  - All eight digits of a frame therefore come from one coherent sample. Port changes mid-frame appear at the next frame.
  - snap resets to 0, so the first frame after reset shows "00" on all ports.

- **Digit mapping.**
  - Digit 2p shows snap[p][3:0].
  - Digit 2p+1 shows snap[p][7:4].

- **Outputs (registered, every edge).**
  - seg_an ← ~(8'b1 << digit).
  - seg_n ← ~enc(nibble).
  - enc, active-high hex values: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.

## Timing
- **Reset values** (on any edge with resetn=0, including mid-operation):
  - in_port0=0, in_port1=0, in_change=0.
  - seg_an=8'hFF (all digits off), seg_n=7'h7F.
  - s1, s2, cand, cnt, scan_cnt, digit and snap all = 0.
- **Debounce latency.**
  - Let raw sw change before edge E0 and stay stable.
  - in_port updates and in_change pulses at edge E0+DEBOUNCE_CYCLES+2.
  - With the default of 16, that is 18 edges after E0, 19 edges counting E0 itself.
- **Display cadence.**
  - First edge after reset release: seg_an=8'hFE, seg_n=7'h40.
  - Each digit holds for SCAN_CYCLES cycles; a full frame is 8·SCAN_CYCLES cycles.
  - seg outputs lag the internal digit by one cycle.
- **Stability.** seg_an always has exactly one bit low outside reset, and is never all-low.

## Test plan
- **Reset mid-scan:** with out_port0=32'hA5, run 20 cycles, assert resetn=0 for 1 edge → seg_an=FF, seg_n=7F, in_port0/1=0, in_change=0. The next edge gives seg_an=FE.
- **Clean switch change:** sw0 0→6'h2D at E0, hold → in_port0=6'h2D and in_change=1 exactly at E0+18, in_change=0 at E0+19.
- **Bounce rejection:** sw1 toggles 6'h00↔6'h3F every 5 cycles for 60 cycles, then settles at 6'h3F → in_port1 stays 0 during toggling and becomes 3F 18 edges after the last transition; exactly one in_change pulse.
- **Simultaneous groups:** sw0=6'h01 and sw1=6'h02 change on the same cycle → both in_port values update on the same edge with a single in_change pulse.
- **Display decode:** out_port0=32'hFFFF_FF3C, out_port3=32'h0000_00E9, SCAN_CYCLES=4, checked over the second frame:
  - seg_an=FE with seg_n=~39=46 ("C").
  - seg_an=FD with seg_n=~4F=30 ("3").
  - seg_an=BF with seg_n=~6F=10 ("9").
  - seg_an=7F with seg_n=~79=06 ("E").
- **Frame coherence:** change out_port1 from 8'h11 to 8'h22 while digit=2 → digits 2/3 show "11" for the rest of that frame and "22" from the next frame onward.
